y86_mem_responder: RTL and testbench
====================================

Y86_MEM_RESPONDER -- requirements
Module: y86_mem_responder

Interface
REQ-001 Parameter ADDR_BITS, default 10, byte-address width of the backing store (2^ADDR_BITS bytes).
REQ-002 Parameter CNT_BITS, default 16, width of each access counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 bus_A  input  32  byte address from CPU.
REQ-006 bus_in  output  32  read data to CPU.
REQ-007 bus_out  input  32  write data from CPU.
REQ-008 bus_WE  input  1  CPU store strobe.
REQ-009 bus_RE  input  1  CPU read strobe.
REQ-010 ld_valid  input  1  preload byte offered.
REQ-011 ld_ready  output  1  preload byte accepted this cycle when high with ld_valid.
REQ-012 ld_addr  input  ADDR_BITS  preload byte address.
REQ-013 ld_data  input  8  preload byte.
REQ-014 rd_count  output  CNT_BITS  completed read accesses.
REQ-015 wr_count  output  CNT_BITS  completed write accesses.
REQ-016 addr_err  output  1  sticky out-of-range access flag.

Function
REQ-017 Storage shall be a byte array; 32-bit accesses are little-endian, unaligned allowed: byte k (0..3) maps to address bus_A+k.
REQ-018 Read: bus_in shall be combinational from bus_A when bus_RE=1 (zero-wait-state, CPU samples same cycle); bus_in=0 when bus_RE=0.
REQ-019 Write: when bus_WE=1, bytes bus_out[8k+7:8k] shall be written to bus_A+k on the rising edge.
REQ-020 Out-of-range byte (bus_A+k >= 2^ADDR_BITS, computed in 33 bits, no wrap): reads return 0x00 for that byte; writes drop that byte; in-range bytes of the same access still complete.
REQ-021 addr_err shall set on the edge after any RE or WE access with at least one out-of-range byte, and hold until rst.
REQ-022 bus_RE and bus_WE both high: write performed, bus_in shows pre-write contents, both counters increment.
REQ-023 rd_count increments by 1 each cycle bus_RE=1 and wr_count each cycle bus_WE=1; both wrap modulo 2^CNT_BITS.
REQ-024 ld_ready shall equal (!rst && !bus_WE); a preload byte is written on an edge where ld_valid && ld_ready.
REQ-025 Preload vs CPU write collision: CPU write wins, preload stalls (ld_ready low), no byte lost; ld_addr/ld_data held by source until accepted.
REQ-026 Preload shall not affect rd_count, wr_count or addr_err.
REQ-027 Read of a byte preloaded or written on edge N shall return the new value from cycle N+1 onward.

Reset
REQ-028 rst shall clear rd_count, wr_count, addr_err to 0 on the next rising edge.
REQ-029 rst shall not clear storage contents; CPU writes and preloads while rst=1 shall be ignored.
REQ-030 bus_in shall still follow REQ-018 while rst=1 (combinational path unaffected).
REQ-031 Reset asserted mid-preload stream: the byte offered that cycle is not written; stream resumes after rst drops.

Structure
REQ-032 Shared package y86_pkg holds ADDR_BITS/CNT_BITS defaults, word/byte width constants, and the little-endian byte-lane helper function.
REQ-033 One sub-module y86_byte_ram: single byte array, 4 combinational read ports, 4 byte write ports with per-lane enable; responder top holds lane address/range logic, arbitration and counters.

Verification
REQ-034 Preload bytes 0x00..0x03 = 11,22,33,44, CPU read bus_A=0 -> bus_in=0x44332211, rd_count=1.
REQ-035 CPU write bus_A=5, bus_out=0xDEADBEEF, then read bus_A=4 -> bus_in=0xADBEEF<byte4>, wr_count=1.
REQ-036 Read bus_A=1022 (ADDR_BITS=10) -> upper two bytes 0x00, addr_err=1 next cycle, stays 1 until rst.
REQ-037 ld_valid held with bus_WE=1 one cycle -> ld_ready=0 that cycle, byte written the following cycle; CPU bytes intact.
REQ-038 Pulse rst after traffic -> counters and addr_err 0, previously written memory still reads back unchanged.
REQ-039 Drive bus_RE=1 for 2^CNT_BITS+2 cycles -> rd_count=2 (wrap).

Source files
------------

// File: rtl/y86_pkg.sv
// Shared definitions for the Y86 memory responder slice.
// Holds default sizes, the word/byte geometry and the little-endian lane
// helpers that every file in this slice uses.
package y86_pkg;

    localparam int ADDR_BITS_DEF = 10;
    localparam int CNT_BITS_DEF  = 16;
    localparam int WORD_W        = 32;
    localparam int BYTE_W        = 8;
    localparam int LANES         = WORD_W / BYTE_W;

    // Byte lane k of a little-endian word (lane 0 is the least significant byte).
    function automatic logic [BYTE_W-1:0] lane_byte(input logic [WORD_W-1:0] word,
                                                    input int                k);
        return word[BYTE_W*k +: BYTE_W];
    endfunction

    // Address of lane k, kept in 33 bits so base+k never wraps.
    function automatic logic [WORD_W:0] lane_addr(input logic [WORD_W-1:0] base,
                                                  input int                k);
        return {1'b0, base} + (WORD_W+1)'(k);
    endfunction

endpackage

// File: rtl/y86_mem_responder_if.sv
// CPU bus plus byte-preload channel of the memory responder.
//   bus_A/bus_out/bus_WE/bus_RE : CPU address, write data, store and read strobes
//   bus_in                      : combinational read data back to the CPU
//   ld_valid/ld_addr/ld_data    : preload byte offer
//   ld_ready                    : preload byte accepted when high with ld_valid
// master = CPU/loader side, slave = responder side.
interface y86_mem_responder_if
    import y86_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_BITS_DEF
);
    logic [WORD_W-1:0]    bus_A;
    logic [WORD_W-1:0]    bus_in;
    logic [WORD_W-1:0]    bus_out;
    logic                 bus_WE;
    logic                 bus_RE;
    logic                 ld_valid;
    logic                 ld_ready;
    logic [ADDR_BITS-1:0] ld_addr;
    logic [BYTE_W-1:0]    ld_data;

    modport master (
        output bus_A, bus_out, bus_WE, bus_RE, ld_valid, ld_addr, ld_data,
        input  bus_in, ld_ready
    );

    modport slave (
        input  bus_A, bus_out, bus_WE, bus_RE, ld_valid, ld_addr, ld_data,
        output bus_in, ld_ready
    );

endinterface

// File: rtl/y86_byte_ram.sv
// Byte-wide storage with four combinational read ports and four byte write
// ports, one per lane of a 32-bit access.
//   clk     : write clock
//   rd_addr : per-lane read address, rd_data : per-lane read byte
//   wr_en   : per-lane write enable, wr_addr/wr_data : per-lane write address/byte
// Contents are never reset.
module y86_byte_ram
    import y86_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_BITS_DEF
) (
    input  logic                 clk,
    input  logic [ADDR_BITS-1:0] rd_addr [LANES],
    output logic [BYTE_W-1:0]    rd_data [LANES],
    input  logic [LANES-1:0]     wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr [LANES],
    input  logic [BYTE_W-1:0]    wr_data [LANES]
);

    logic [BYTE_W-1:0] mem [0:(1<<ADDR_BITS)-1];

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            rd_data[k] = mem[rd_addr[k]];
        end
    end

    // Lane addresses of one access are distinct (base+k without wrap), so
    // at most one enabled lane targets any byte in a cycle.
    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (wr_en[k]) begin
                mem[wr_addr[k]] <= wr_data[k];
            end
        end
    end

endmodule

// File: rtl/y86_mem_responder.sv
// Zero-wait-state memory responder for a Y86 CPU bus with a byte preload port.
//   clk, rst : clock, synchronous active-high reset
//   bus      : CPU bus and preload channel (slave modport)
//   rd_count : CPU read cycles seen (wraps)
//   wr_count : CPU write cycles seen (wraps)
//   addr_err : sticky flag, set after any access touching a byte beyond the store
// Accesses are 32-bit little-endian and may be unaligned; out-of-range bytes
// read as zero and are not written. Reset clears counters and the flag only.
module y86_mem_responder
    import y86_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_BITS_DEF,
    parameter int CNT_BITS  = CNT_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    y86_mem_responder_if.slave  bus,
    output logic [CNT_BITS-1:0] rd_count,
    output logic [CNT_BITS-1:0] wr_count,
    output logic                addr_err
);

    logic [WORD_W:0]       lane_a  [LANES];
    logic [LANES-1:0]      lane_ok;
    logic [ADDR_BITS-1:0]  rd_addr [LANES];
    logic [BYTE_W-1:0]     rd_data [LANES];
    logic [LANES-1:0]      wr_en;
    logic [ADDR_BITS-1:0]  wr_addr [LANES];
    logic [BYTE_W-1:0]     wr_data [LANES];
    logic [WORD_W-1:0]     rd_word;
    logic                  cpu_we;
    logic                  ld_fire;
    logic                  range_hit;

    assign cpu_we       = bus.bus_WE && !rst;
    assign bus.ld_ready = !rst && !bus.bus_WE;
    assign ld_fire      = bus.ld_valid && bus.ld_ready;
    assign bus.bus_in   = rd_word;
    assign range_hit    = (bus.bus_RE || bus.bus_WE) && !(&lane_ok);

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_a[k]  = lane_addr(bus.bus_A, k);
            lane_ok[k] = (lane_a[k] >> ADDR_BITS) == '0;
            rd_addr[k] = lane_a[k][ADDR_BITS-1:0];
            wr_addr[k] = lane_a[k][ADDR_BITS-1:0];
            wr_data[k] = lane_byte(bus.bus_out, k);
            wr_en[k]   = cpu_we && lane_ok[k];
            if (bus.bus_RE && lane_ok[k]) begin
                rd_word[BYTE_W*k +: BYTE_W] = rd_data[k];
            end
        end
        // Preload borrows lane 0's write port; it only fires when no CPU
        // store is present, so the two never compete for the port.
        if (!bus.bus_WE) begin
            wr_en[0]   = ld_fire;
            wr_addr[0] = bus.ld_addr;
            wr_data[0] = bus.ld_data;
        end
    end

    y86_byte_ram #(
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk     (clk),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count <= '0;
            wr_count <= '0;
            addr_err <= 1'b0;
        end else begin
            if (bus.bus_RE) rd_count <= rd_count + CNT_BITS'(1);
            if (bus.bus_WE) wr_count <= wr_count + CNT_BITS'(1);
            if (range_hit)  addr_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_y86_mem_responder.sv
// Directed-vector bench for y86_mem_responder. Stimulus pushes tagged
// expectations into a scoreboard queue; a monitor on the falling edge pops
// every expectation due in the current cycle and compares it.
module tb_y86_mem_responder;
    import y86_pkg::*;

    localparam int AB = 10;
    localparam int CB = 16;

    localparam int S_BUSIN = 0;
    localparam int S_RD    = 1;
    localparam int S_WR    = 2;
    localparam int S_ERR   = 3;
    localparam int S_LDRDY = 4;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [CB-1:0] rd_count;
    logic [CB-1:0] wr_count;
    logic          addr_err;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    y86_mem_responder_if #(.ADDR_BITS(AB)) bus ();

    y86_mem_responder #(
        .ADDR_BITS (AB),
        .CNT_BITS  (CB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .rd_count (rd_count),
        .wr_count (wr_count),
        .addr_err (addr_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t        it;
        logic [31:0] act;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            it = exp_q.pop_front();
            case (it.sel)
                S_BUSIN: act = bus.bus_in;
                S_RD:    act = 32'(rd_count);
                S_WR:    act = 32'(wr_count);
                S_ERR:   act = 32'(addr_err);
                default: act = 32'(bus.ld_ready);
            endcase
            checks++;
            if (it.cyc != cyc || act !== it.exp) begin
                errors++;
                $display("FAIL %s (cycle %0d, due %0d): got %h expected %h",
                         it.name, cyc, it.cyc, act, it.exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance one cycle, then apply this cycle's inputs.
    task automatic drive(input logic r, input logic [31:0] a, input logic [31:0] o,
                         input logic we, input logic re, input logic lv,
                         input logic [AB-1:0] la, input logic [7:0] ld);
        step();
        rst          = r;
        bus.bus_A    = a;
        bus.bus_out  = o;
        bus.bus_WE   = we;
        bus.bus_RE   = re;
        bus.ld_valid = lv;
        bus.ld_addr  = la;
        bus.ld_data  = ld;
    endtask

    task automatic expect_now(input int sel, input logic [31:0] v, input string nm);
        exp_t e;
        e.cyc  = cyc;
        e.sel  = sel;
        e.exp  = v;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pre [5];
        pre[0] = 8'h11; pre[1] = 8'h22; pre[2] = 8'h33; pre[3] = 8'h44; pre[4] = 8'h55;

        rst = 1'b1;
        bus.bus_A = '0; bus.bus_out = '0; bus.bus_WE = 1'b0; bus.bus_RE = 1'b0;
        bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;

        drive(1, 0, 0, 0, 0, 0, 0, 0);
        expect_now(S_LDRDY, 0, "ld_ready_in_reset");
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        expect_now(S_RD, 0, "reset_rd_count");
        expect_now(S_WR, 0, "reset_wr_count");
        expect_now(S_ERR, 0, "reset_addr_err");
        expect_now(S_LDRDY, 1, "ld_ready_idle");

        // Preload bytes 0..4
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 1, AB'(i), pre[i]);

        drive(0, 0, 0, 0, 1, 0, 0, 0);
        expect_now(S_BUSIN, 32'h44332211, "read_preload_a0");
        expect_now(S_RD, 0, "rd_before_first_read");

        drive(0, 5, 32'hDEADBEEF, 1, 0, 0, 0, 0);
        expect_now(S_BUSIN, 0, "bus_in_zero_no_re");
        expect_now(S_RD, 1, "rd_after_first_read");

        drive(0, 4, 0, 0, 1, 0, 0, 0);
        expect_now(S_BUSIN, 32'hADBEEF55, "read_unaligned_a4");
        expect_now(S_WR, 1, "wr_after_first_write");

        // Simultaneous read and write: read shows pre-write contents
        drive(0, 5, 32'h01020304, 1, 1, 0, 0, 0);
        expect_now(S_BUSIN, 32'hDEADBEEF, "rw_pre_write_data");
        expect_now(S_RD, 2, "rd_before_rw");

        drive(0, 5, 0, 0, 1, 0, 0, 0);
        expect_now(S_BUSIN, 32'h01020304, "rw_written_data");
        expect_now(S_RD, 3, "rd_after_rw");
        expect_now(S_WR, 2, "wr_after_rw");

        // Preload collides with a CPU store: preload stalls one cycle
        drive(0, 12, 32'hCAFEF00D, 1, 0, 1, 16, 8'h77);
        expect_now(S_LDRDY, 0, "ld_ready_collision");
        drive(0, 12, 0, 0, 0, 1, 16, 8'h77);
        expect_now(S_LDRDY, 1, "ld_ready_after_collision");
        drive(0, 13, 0, 0, 1, 0, 0, 0);
        expect_now(S_BUSIN, 32'h77CAFEF0, "collision_bytes_intact");
        expect_now(S_WR, 3, "wr_after_collision");

        // Top-of-store access, then partially out of range
        drive(0, 1020, 32'h99887766, 1, 0, 0, 0, 0);
        drive(0, 1022, 0, 0, 1, 0, 0, 0);
        expect_now(S_BUSIN, 32'h00009988, "read_oob_upper_zero");
        expect_now(S_ERR, 0, "err_clear_in_range");
        drive(0, 1023, 32'h11111142, 1, 0, 0, 0, 0);
        expect_now(S_ERR, 1, "err_set_after_oob_read");
        drive(0, 1020, 0, 0, 1, 0, 0, 0);
        expect_now(S_BUSIN, 32'h42887766, "oob_write_partial");
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        expect_now(S_BUSIN, 32'h44332211, "oob_write_no_wrap");
        expect_now(S_ERR, 1, "err_sticky");

        // Reset with traffic: store and preload ignored, read path live
        drive(1, 0, 32'h12345678, 1, 1, 1, 4, 8'hAB);
        expect_now(S_BUSIN, 32'h44332211, "read_during_reset");
        expect_now(S_LDRDY, 0, "ld_ready_reset_traffic");
        expect_now(S_RD, 8, "rd_before_reset");
        expect_now(S_WR, 5, "wr_before_reset");
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        expect_now(S_RD, 0, "rd_cleared");
        expect_now(S_WR, 0, "wr_cleared");
        expect_now(S_ERR, 0, "err_cleared");
        drive(0, 1, 0, 0, 1, 0, 0, 0);
        expect_now(S_BUSIN, 32'h55443322, "mem_kept_over_reset");
        drive(0, 0, 0, 0, 0, 1, 4, 8'hAB);
        expect_now(S_LDRDY, 1, "preload_resumes");
        drive(0, 4, 0, 0, 1, 0, 0, 0);
        expect_now(S_BUSIN, 32'h020304AB, "preload_after_reset");
        expect_now(S_RD, 1, "rd_after_reset_read");

        // Counter wrap
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < (1 << CB) + 2; i++) drive(0, 0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        expect_now(S_RD, 2, "rd_count_wrap");
        expect_now(S_WR, 0, "wr_no_change_wrap");
        expect_now(S_ERR, 0, "err_no_change_wrap");

        step();
        step();
        if (exp_q.size() != 0) begin
            errors += exp_q.size();
            checks += exp_q.size();
            $display("FAIL scoreboard_drain: %0d expectations left unchecked", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
